uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// registered one-cycle valid / frame_err strobes and a busy flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n;
  logic          rx_m, rx_s;

  // Idle-high synchronizer so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      busy      <= (state_n != IDLE);
    end
  end

  // valid is a one-cycle strobe with no ready: the consumer must take data
  // in that cycle; data then holds until the next good frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n          = '0;
          shreg_n[idx]   = rx_s;
          idx_n          = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        // Line break: ignore a low line until it has returned high.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: good frames, false start,
// framing error with break, back-to-back frames, mid-frame reset, bit-period skew.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;

  int valid_cnt = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got_q[$];
  int         vtime_q[$];
  int         ftime_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // Clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples outputs on the falling edge
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt <= valid_cnt + 1;
      got_q.push_back(data);
      vtime_q.push_back(cyc);
    end
    if (frame_err) begin
      ferr_cnt <= ferr_cnt + 1;
      ftime_q.push_back(cyc);
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (valid && frame_err) both_cnt <= both_cnt + 1;
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int len);
    rx = b;
    wait_cyc(len);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int len);
    send_bit(1'b0, len);
    for (int i = 0; i < 8; i++) send_bit(d[i], len);
    send_bit(stop, len);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    vec_cnt++; if (data !== 8'h00) begin miss_cnt++; $display("FAIL reset_data got %h exp 00", data); end
    vec_cnt++; if (valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_valid got %b exp 0", valid); end
    vec_cnt++; if (frame_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cyc(5);
  endtask

  task automatic test_good_frame;
    int v0, f0, g0, t0, lat;
    v0 = valid_cnt; f0 = ferr_cnt; g0 = got_q.size();
    exp_q.push_back(8'hA5);
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 16);
    wait_cyc(20);
    vec_cnt++; if (valid_cnt - v0 !== 1) begin miss_cnt++; $display("FAIL good_valid_count got %0d exp 1", valid_cnt - v0); end
    vec_cnt++; if (data !== 8'hA5) begin miss_cnt++; $display("FAIL good_data got %h exp a5", data); end
    if (got_q.size() > g0) begin
      vec_cnt++; if (got_q[g0] !== exp_q[0]) begin miss_cnt++; $display("FAIL good_strobe_data got %h exp %h", got_q[g0], exp_q[0]); end
      lat = vtime_q[g0] - t0;
      vec_cnt++; if (lat < 153 || lat > 155) begin miss_cnt++; $display("FAIL good_latency got %0d exp 154+-1", lat); end
    end
    void'(exp_q.pop_front());
    vec_cnt++; if (ferr_cnt - f0 !== 0) begin miss_cnt++; $display("FAIL good_ferr got %0d exp 0", ferr_cnt - f0); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL good_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_false_start;
    int v0, f0, b0;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    send_bit(1'b0, 4);
    send_bit(1'b1, 40);
    vec_cnt++; if (valid_cnt - v0 !== 0) begin miss_cnt++; $display("FAIL fs_valid got %0d exp 0", valid_cnt - v0); end
    vec_cnt++; if (ferr_cnt - f0 !== 0) begin miss_cnt++; $display("FAIL fs_ferr got %0d exp 0", ferr_cnt - f0); end
    vec_cnt++; if (busy_cnt - b0 < 1 || busy_cnt - b0 > 10) begin miss_cnt++; $display("FAIL fs_busy_cycles got %0d exp 1..10", busy_cnt - b0); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL fs_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_frame_error;
    int v0, f0, t0, lat;
    v0 = valid_cnt; f0 = ferr_cnt;
    t0 = cyc;
    send_frame(8'h3C, 1'b0, 16);
    wait_cyc(40);
    vec_cnt++; if (ferr_cnt - f0 !== 1) begin miss_cnt++; $display("FAIL fe_ferr_count got %0d exp 1", ferr_cnt - f0); end
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL fe_busy_break got %b exp 1", busy); end
    vec_cnt++; if (data !== 8'hA5) begin miss_cnt++; $display("FAIL fe_data_held got %h exp a5", data); end
    if (ferr_cnt > f0) begin
      lat = ftime_q[f0] - t0;
      vec_cnt++; if (lat < 153 || lat > 155) begin miss_cnt++; $display("FAIL fe_latency got %0d exp 154+-1", lat); end
    end
    rx = 1'b1;
    wait_cyc(200);
    vec_cnt++; if (valid_cnt - v0 !== 0) begin miss_cnt++; $display("FAIL fe_valid got %0d exp 0", valid_cnt - v0); end
    vec_cnt++; if (ferr_cnt - f0 !== 1) begin miss_cnt++; $display("FAIL fe_ferr_after got %0d exp 1", ferr_cnt - f0); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL fe_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back;
    int v0, f0, g0, gap;
    v0 = valid_cnt; f0 = ferr_cnt; g0 = got_q.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 16);
    send_frame(8'hFF, 1'b1, 16);
    wait_cyc(20);
    vec_cnt++; if (valid_cnt - v0 !== 2) begin miss_cnt++; $display("FAIL b2b_valid_count got %0d exp 2", valid_cnt - v0); end
    for (int i = 0; i < 2; i++) begin
      if (got_q.size() > g0 + i) begin
        vec_cnt++; if (got_q[g0 + i] !== exp_q[0]) begin miss_cnt++; $display("FAIL b2b_data%0d got %h exp %h", i, got_q[g0 + i], exp_q[0]); end
      end
      void'(exp_q.pop_front());
    end
    if (vtime_q.size() > g0 + 1) begin
      gap = vtime_q[g0 + 1] - vtime_q[g0];
      vec_cnt++; if (gap < 159 || gap > 161) begin miss_cnt++; $display("FAIL b2b_spacing got %0d exp 160+-1", gap); end
    end
    vec_cnt++; if (ferr_cnt - f0 !== 0) begin miss_cnt++; $display("FAIL b2b_ferr got %0d exp 0", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0;
    logic [7:0] d;
    d = 8'hF0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(d[i], 16);
    rx = d[3];
    wait_cyc(8);
    #2 reset = 1'b1;
    #1;
    vec_cnt++; if (data !== 8'h00) begin miss_cnt++; $display("FAIL mr_data got %h exp 00", data); end
    vec_cnt++; if (valid !== 1'b0) begin miss_cnt++; $display("FAIL mr_valid got %b exp 0", valid); end
    vec_cnt++; if (frame_err !== 1'b0) begin miss_cnt++; $display("FAIL mr_ferr got %b exp 0", frame_err); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL mr_busy got %b exp 0", busy); end
    wait_cyc(4);
    rx = 1'b1;
    reset = 1'b0;
    wait_cyc(200);
    vec_cnt++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin miss_cnt++; $display("FAIL mr_aborted_pulses got v=%0d f=%0d exp 0/0", valid_cnt - v0, ferr_cnt - f0); end
    send_frame(8'h5A, 1'b1, 16);
    wait_cyc(20);
    vec_cnt++; if (valid_cnt - v0 !== 1) begin miss_cnt++; $display("FAIL mr_valid_count got %0d exp 1", valid_cnt - v0); end
    vec_cnt++; if (data !== 8'h5A) begin miss_cnt++; $display("FAIL mr_data_after got %h exp 5a", data); end
    vec_cnt++; if (ferr_cnt - f0 !== 0) begin miss_cnt++; $display("FAIL mr_ferr_after got %0d exp 0", ferr_cnt - f0); end
  endtask

  task automatic test_bit_skew;
    int v0;
    int lens[10];
    logic [7:0] d;
    d = 8'h81;
    // Slow sender: every bit 17 cycles.
    v0 = valid_cnt;
    send_frame(d, 1'b1, 17);
    wait_cyc(30);
    vec_cnt++; if (valid_cnt - v0 !== 1) begin miss_cnt++; $display("FAIL skew_slow_valid got %0d exp 1", valid_cnt - v0); end
    vec_cnt++; if (data !== 8'h81) begin miss_cnt++; $display("FAIL skew_slow_data got %h exp 81", data); end
    // Clear data with a different byte so the next check sees a fresh load.
    send_frame(8'h18, 1'b1, 16);
    wait_cyc(20);
    // Jittery sender: periods alternate between 15 and 17 cycles.
    lens = '{16, 15, 17, 15, 17, 15, 17, 15, 17, 16};
    v0 = valid_cnt;
    send_bit(1'b0, lens[0]);
    for (int i = 0; i < 8; i++) send_bit(d[i], lens[i + 1]);
    send_bit(1'b1, lens[9]);
    wait_cyc(20);
    vec_cnt++; if (valid_cnt - v0 !== 1) begin miss_cnt++; $display("FAIL skew_jitter_valid got %0d exp 1", valid_cnt - v0); end
    vec_cnt++; if (data !== 8'h81) begin miss_cnt++; $display("FAIL skew_jitter_data got %h exp 81", data); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_false_start;
    test_frame_error;
    test_back_to_back;
    test_reset_mid_frame;
    test_bit_skew;
    vec_cnt++; if (both_cnt !== 0) begin miss_cnt++; $display("FAIL valid_ferr_overlap got %0d exp 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
